ps2_key_tracker: RTL
====================

# ps2_key_tracker

Receives the serial PS/2 keyboard stream, decodes scan-code set 2 make/break sequences and maintains a table of up to four currently held keys. The table drives `keycode`, `keycode2`, `keycode3` and `keycode4`, the four slots the player and game-control logic compare against their direction and fire keys. It replaces the software keycode path, so gameplay needs no processor.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive equal `Clk` samples needed to accept a new `ps2_clk` level (glitch filter).
- TIMEOUT, 50000: `Clk` cycles without a filtered `ps2_clk` falling edge mid-frame before the frame is abandoned. This is 1 ms at 50 MHz.

Ports:
- Clk  in  1  system clock, 50 MHz. This is the block's only clock.
- Reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  keyboard clock, asynchronous to `Clk`, open-drain.
- ps2_data  in  1  keyboard data, asynchronous to `Clk`.
- keycode, keycode2, keycode3, keycode4  out  8 each  held-key slots 1–4. The value 0x00 means the slot is empty.
- scan_byte  out  8  last correctly framed byte.
- scan_strobe  out  1  one-cycle pulse when `scan_byte` updates.
- frame_err  out  1  one-cycle pulse when a frame is rejected (bad start, parity, stop or timeout).
- overflow  out  1  one-cycle pulse when a make code is dropped because the table is full.

## Operation
**Input conditioning**
- `ps2_clk` and `ps2_data` pass through a 2-FF synchronizer.
- `ps2_clk` then passes through a FILTER_LEN-sample filter. The filtered level changes only after FILTER_LEN identical samples.
- A falling edge is detected on the filtered clock. `ps2_data` (synchronized) is sampled in the same cycle the falling edge is detected.

**Receiver FSM: IDLE → DATA → PARITY → STOP → IDLE**
- IDLE: on a falling edge, if data = 0 go to DATA with the bit count cleared. If data = 1, stay in IDLE and pulse `frame_err`.
- DATA: shift in 8 bits, LSB first.
- PARITY: the received bit must make odd parity over the 8 data bits plus the parity bit.
- STOP: the received bit must be 1.
  - If parity and stop are both good: load `scan_byte` and pulse `scan_strobe`.
  - Otherwise: pulse `frame_err` and discard the byte.
- Timeout: in any state other than IDLE, a timeout counter counts cycles since the last falling edge. When it reaches TIMEOUT, return to IDLE and pulse `frame_err`. The counter is ceil(log2(TIMEOUT+1)) bits wide and clears on every falling edge.

**Decoder FSM: NORM, E0, F0, E0F0, SKIP** (advances only on `scan_strobe`)
- From NORM:
  - 0xE0 → E0.
  - 0xF0 → F0.
  - 0xE1 → SKIP with a skip counter of 7.
  - 0xAA → clear all slots.
  - 0xFA, 0xFE, 0xEE, 0x00, 0xFF → ignored.
  - 0x83 → ignored.
  - Any other value c → make(c).
- From E0:
  - 0xF0 → E0F0.
  - 0x12 → ignored (fake shift), return to NORM.
  - Any other value c → make(c | 0x80), return to NORM.
- From F0: byte c → break(c), return to NORM.
- From E0F0:
  - 0x12 → ignored, return to NORM.
  - Any other value c → break(c | 0x80), return to NORM.
- SKIP: consume bytes, decrementing the skip counter. Return to NORM when it reaches 0.

**make(k)**
- If k is already in a slot: no change (typematic repeat).
- Otherwise, if a free slot exists: write k into the lowest-numbered empty slot.
- Otherwise (table full): drop k and pulse `overflow`.

**break(k)**
- Clear every slot equal to k to 0x00.
- Other slots do not move (no compaction).
- A break for a key not in the table has no effect.

## Timing
- Reset values:
  - All keycode outputs: 0x00.
  - `scan_byte`: 0x00.
  - `scan_strobe`, `frame_err`, `overflow`: 0.
  - Both FSMs: IDLE / NORM.
  - Filter: filtered clock level 1.
  - Counters: cleared.
- Reset mid-frame or mid-sequence discards all partial state. Only frames whose start bit arrives after Reset deasserts are decoded.
- Cycle reference: cycle N is the cycle in which the stop-bit falling edge is detected. `scan_byte` and `scan_strobe` are registered at edge N+1.
- Slot tables update one cycle after `scan_strobe` (N+2).
- `overflow` pulses in the same cycle as the slot update.
- Detection cycle N trails the physical falling edge by the 2 synchronizer stages plus FILTER_LEN cycles.
- A make and a break never coincide, because at most one byte is processed per `scan_strobe`.
- Keycode outputs are registered and glitch-free. They change only in the update cycle.

## Test plan
- Make 0x1C, then F0 1C. Required: `keycode` = 0x1C after the first byte; all slots 0x00 after the break; 3 `scan_strobe` pulses total.
- E0 74 (right arrow), then E0 6B (left arrow). Required: `keycode` = 0xF4, `keycode2` = 0xEB. Then E0 F0 74. Required: `keycode` = 0x00 and `keycode2` = 0xEB, with no shift.
- Makes 1C, 1B, 23, 2B, 34. Required: the slots hold 1C, 1B, 23, 2B; one `overflow` pulse on 0x34. Then repeat 1C three times. Required: no change and no `overflow`.
- Frame for 0x1C with the parity bit inverted. Required: `frame_err` pulse, no `scan_strobe`, slots unchanged. A following good 0x1C frame must still decode.
- Stop toggling `ps2_clk` after 4 data bits. Required: `frame_err` exactly TIMEOUT cycles after the last falling edge, then correct decode of the next complete frame.
- With slots holding values, assert Reset mid-frame. Required: all outputs 0x00/0 while Reset is high. The frame remainder delivered after Reset deasserts produces no `scan_strobe` (framing error or timeout only).

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 receiver and decoder that keeps a four-slot table of currently held keys.
// Latency: scan_byte/scan_strobe 1 cycle after stop-bit edge detection; slots and overflow 1 cycle later.
// Backpressure: none; the keyboard cannot be stalled, so bad frames pulse frame_err and extra makes pulse overflow.
module ps2_key_tracker #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic [7:0] keycode2,
  output logic [7:0] keycode3,
  output logic [7:0] keycode4,
  output logic [7:0] scan_byte,
  output logic       scan_strobe,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {DEC_NORM, DEC_E0, DEC_F0, DEC_E0F0, DEC_SKIP} dec_state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_clk_d;
  logic          fall;

  rx_state_t     rx_state, rx_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_ok;
  logic [TW-1:0] to_cnt;
  logic          timed_out;
  logic          shift_en, cnt_clr, par_load, byte_ok, rx_err;

  dec_state_t    dec_state, dec_next;
  logic [2:0]    skip_cnt, skip_next;
  logic          do_make, do_break, do_clear;
  logic [7:0]    key;

  logic [7:0]    slot      [4];
  logic [7:0]    slot_next [4];
  logic          ovf_next;
  logic          hit, has_free;
  logic [1:0]    free_idx;

  // Idle bus level is high, so the synchronizers reset to 1 to avoid a phantom edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = filt_clk_d & ~filt_clk;

  always_comb begin
    rx_next   = rx_state;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    par_load  = 1'b0;
    byte_ok   = 1'b0;
    rx_err    = 1'b0;
    timed_out = (rx_state != RX_IDLE) && !fall && (to_cnt == TW'(TIMEOUT - 1));
    case (rx_state)
      RX_IDLE: begin
        if (fall) begin
          if (!dat_s2) begin
            rx_next = RX_DATA;
            cnt_clr = 1'b1;
          end else begin
            rx_err = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) rx_next = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_load = 1'b1;
          rx_next  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          rx_next = RX_IDLE;
          if (parity_ok && dat_s2) byte_ok = 1'b1;
          else                     rx_err  = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
    if (timed_out) begin
      rx_next = RX_IDLE;
      rx_err  = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      parity_ok   <= 1'b0;
      to_cnt      <= '0;
      scan_byte   <= '0;
      scan_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (cnt_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {dat_s2, shreg[7:1]};
      // Odd parity: data bits plus parity bit must XOR to 1.
      if (par_load) parity_ok <= ^{dat_s2, shreg};
      if (fall || rx_state == RX_IDLE || timed_out) to_cnt <= '0;
      else                                          to_cnt <= to_cnt + TW'(1);
      scan_strobe <= byte_ok;
      if (byte_ok) scan_byte <= shreg;
      frame_err <= rx_err;
    end
  end

  always_comb begin
    dec_next  = dec_state;
    skip_next = skip_cnt;
    do_make   = 1'b0;
    do_break  = 1'b0;
    do_clear  = 1'b0;
    key       = scan_byte;
    if (scan_strobe) begin
      case (dec_state)
        DEC_NORM: begin
          case (scan_byte)
            8'hE0: dec_next = DEC_E0;
            8'hF0: dec_next = DEC_F0;
            8'hE1: begin
              dec_next  = DEC_SKIP;
              skip_next = 3'd7;
            end
            8'hAA: do_clear = 1'b1;
            8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'h83: begin
            end
            default: do_make = 1'b1;
          endcase
        end
        DEC_E0: begin
          if (scan_byte == 8'hF0) begin
            dec_next = DEC_E0F0;
          end else begin
            dec_next = DEC_NORM;
            key      = scan_byte | 8'h80;
            do_make  = (scan_byte != 8'h12);
          end
        end
        DEC_F0: begin
          dec_next = DEC_NORM;
          do_break = 1'b1;
        end
        DEC_E0F0: begin
          dec_next = DEC_NORM;
          key      = scan_byte | 8'h80;
          do_break = (scan_byte != 8'h12);
        end
        DEC_SKIP: begin
          skip_next = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) dec_next = DEC_NORM;
        end
        default: dec_next = DEC_NORM;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dec_state <= DEC_NORM;
      skip_cnt  <= '0;
    end else begin
      dec_state <= dec_next;
      skip_cnt  <= skip_next;
    end
  end

  always_comb begin
    hit      = 1'b0;
    has_free = 1'b0;
    free_idx = 2'd0;
    ovf_next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slot_next[i] = slot[i];
      if (slot[i] == key) hit = 1'b1;
    end
    // Scan downward so the lowest-numbered empty slot wins.
    for (int i = 3; i >= 0; i--) begin
      if (slot[i] == 8'h00) begin
        has_free = 1'b1;
        free_idx = 2'(i);
      end
    end
    if (do_clear) begin
      for (int i = 0; i < 4; i++) slot_next[i] = 8'h00;
    end else if (do_make && !hit) begin
      if (has_free) slot_next[free_idx] = key;
      else          ovf_next = 1'b1;
    end else if (do_break) begin
      for (int i = 0; i < 4; i++) begin
        if (slot[i] == key) slot_next[i] = 8'h00;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) slot[i] <= 8'h00;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) slot[i] <= slot_next[i];
      overflow <= ovf_next;
    end
  end

  assign keycode  = slot[0];
  assign keycode2 = slot[1];
  assign keycode3 = slot[2];
  assign keycode4 = slot[3];

endmodule
